// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] PC_STEP   = 32'd4;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch queue: DEPTH-entry circular buffer of fetch entries with synchronous flush.
// Head reads zero while empty; push and pop may coincide when full.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  fetch_entry_t wdata_i,
  output fetch_entry_t head_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_FULL = DEPTH[PTR_W:0];

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  // Pointer and occupancy next state; flush wins over any push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_FULL);
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/instruction_fetch.sv
// PC generator and prefetch queue feeding decode from a combinational ROM.
// Optional accepted-instruction counter enabled by IFETCH_PERF_COUNT_EN.
module instruction_fetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] fetch_count
);

  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         fifo_empty, fifo_full;
  logic         do_push, do_pop;
  fetch_entry_t head;
  fetch_entry_t wentry;

  // A redirect flushes the queue, so neither push nor pop takes effect in that cycle.
  assign do_pop  = out_valid && out_ready && !redirect_valid;
  assign do_push = !redirect_valid && (!fifo_full || do_pop);

  assign wentry.pc    = fetch_pc_q;
  assign wentry.instr = imem_data;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = align_pc(redirect_pc);
    end else if (do_push) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end else begin
      fetch_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= align_pc(RESET_PC);
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid),
    .push_i  (do_push),
    .pop_i   (do_pop),
    .wdata_i (wentry),
    .head_o  (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign imem_addr = {2'b00, fetch_pc_q[31:2]};
  assign out_valid = !fifo_empty;
  assign out_instr = head.instr;
  assign out_pc    = head.pc;

`ifdef IFETCH_PERF_COUNT_EN
  logic [31:0] count_q, count_d;

  always_comb begin
    if (do_pop) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 32'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign fetch_count = count_q;
`else
  assign fetch_count = 32'h0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch using the Fibonacci program ROM.
module tb_instruction_fetch;
  import ifetch_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] fetch_count;

  int total = 0;
  int bad   = 0;
  logic [31:0] hs_cnt = 32'd0;
  logic [31:0] cnt_mask;

  instruction_fetch #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (imem_addr)
      32'd0:   imem_data = 32'h1230_0293;
      32'd1:   imem_data = 32'h1234_5337;
      32'd2:   imem_data = 32'h6783_0313;
      32'd8:   imem_data = 32'h0055_0333;
      32'd9:   imem_data = 32'h0050_0533;
      32'd10:  imem_data = 32'h0060_02b3;
      32'd11:  imem_data = 32'hfe00_0ae3;
      32'd12:  imem_data = 32'hdead_beef;
      default: imem_data = INSTR_NOP;
    endcase
  end

  // Reference handshake count: accepted heads, excluding redirect cycles, cleared by rst.
  always @(negedge clk) begin
    if (rst) begin
      hs_cnt <= 32'd0;
    end else if (out_valid && out_ready && !redirect_valid) begin
      hs_cnt <= hs_cnt + 32'd1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] instr);
    check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check_eq({tag, "_pc"}, out_pc, pc);
    check_eq({tag, "_instr"}, out_instr, instr);
  endtask

  initial begin
`ifdef IFETCH_PERF_COUNT_EN
    cnt_mask = 32'hFFFF_FFFF;
`else
    cnt_mask = 32'h0000_0000;
`endif
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    out_ready = 1'b1;
    tick();
    tick();
    check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_instr", out_instr, 32'h0);
    check_eq("rst_pc", out_pc, 32'h0);
    check_eq("rst_addr", imem_addr, 32'h0);
    check_eq("rst_count", fetch_count, 32'h0);

    // 1: streaming after reset release
    rst = 1'b0;
    check_eq("rel_valid0", {31'd0, out_valid}, 32'd0);
    tick();
    check_head("t1_a", 32'h0, 32'h1230_0293);
    tick();
    check_head("t1_b", 32'h4, 32'h1234_5337);
    tick();
    check_head("t1_c", 32'h8, 32'h6783_0313);

    // 2: backpressure from a fresh start
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_head("t2_hold", 32'h0, 32'h1230_0293);
    end
    check_eq("t2_addr", imem_addr, 32'd2);
    out_ready = 1'b1;
    tick();
    check_head("t2_r1", 32'h4, 32'h1234_5337);
    tick();
    check_head("t2_r2", 32'h8, 32'h6783_0313);
    tick();
    check_head("t2_r3", 32'hC, INSTR_NOP);

    // 3: redirect while a head is offered and accepted
    check_eq("t3_pre_valid", {31'd0, out_valid}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h20;
    tick();
    redirect_valid = 1'b0;
    check_eq("t3_bubble", {31'd0, out_valid}, 32'd0);
    check_eq("t3_addr", imem_addr, 32'd8);
    tick();
    check_head("t3_a", 32'h20, 32'h0055_0333);
    tick();
    check_head("t3_b", 32'h24, 32'h0050_0533);
    tick();
    check_head("t3_c", 32'h28, 32'h0060_02b3);

    // 4: misaligned redirect target
    redirect_valid = 1'b1;
    redirect_pc = 32'h2E;
    tick();
    redirect_valid = 1'b0;
    check_eq("t4_bubble", {31'd0, out_valid}, 32'd0);
    tick();
    check_head("t4_a", 32'h2C, 32'hfe00_0ae3);
    tick();
    check_head("t4_b", 32'h30, 32'hdead_beef);

    // 5: counter excludes heads dropped by redirect
    #2;
    check_eq("t5_count", fetch_count, hs_cnt & cnt_mask);
    #1;

    // PC wrap-around
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    check_eq("wrap_addr", imem_addr, 32'h3FFF_FFFF);
    tick();
    check_head("wrap_a", 32'hFFFF_FFFC, INSTR_NOP);
    tick();
    check_head("wrap_b", 32'h0, 32'h1230_0293);

    // 6: reset with queue full overrides a simultaneous redirect
    out_ready = 1'b0;
    tick();
    tick();
    tick();
    check_eq("t6_full_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h20;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    redirect_valid = 1'b0;
    check_eq("t6_valid", {31'd0, out_valid}, 32'd0);
    check_eq("t6_addr", imem_addr, 32'h0);
    check_eq("t6_count", fetch_count, 32'h0);
    tick();
    check_head("t6_a", 32'h0, 32'h1230_0293);
    tick();
    check_head("t6_b", 32'h4, 32'h1234_5337);
    #2;
    check_eq("final_count", fetch_count, hs_cnt & cnt_mask);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
